// File: rtl/loop_counter.sv
// loop_counter: bounded multi-pass up/down counter with pause and abort
module loop_counter #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              down,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  step,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  count,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              wrap,
  output logic              done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d, lim_q, lim_d, step_q, step_d;
  logic [PASS_W-1:0] pass_q, pass_d, last_q, last_d;
  logic              down_q, down_d, wrap_q, wrap_d, done_q, done_d;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  up_next, dn_next, start_val;
  logic              at_term;
  // Step arithmetic: up sum is one bit wider so saturation at limit never wraps
  always_comb begin
    sum       = {1'b0, count_q} + {1'b0, step_q};
    up_next   = (sum > {1'b0, lim_q}) ? lim_q : sum[WIDTH-1:0];
    dn_next   = (count_q >= step_q) ? count_q - step_q : '0;
    start_val = down_q ? lim_q : '0;
    at_term   = down_q ? (count_q == '0) : (count_q == lim_q);
  end
  // Next-state logic: abort first, then per-state behaviour
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pass_d  = pass_q;
    lim_d   = lim_q;
    step_d  = step_q;
    down_d  = down_q;
    last_d  = last_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
      pass_d  = '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        lim_d   = limit;
        step_d  = (step == '0) ? WIDTH'(1) : step;
        down_d  = down;
        last_d  = (passes == '0) ? '0 : passes - PASS_W'(1);
        count_d = down ? limit : '0;
        pass_d  = '0;
        state_d = RUN;
      end
    end else if (state_q != RUN) begin
      state_d = IDLE;
    end else if (!pause) begin
      if (!at_term) begin
        count_d = down_q ? dn_next : up_next;
      end else if (pass_q == last_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        pass_d  = pass_q + PASS_W'(1);
        count_d = start_val;
        wrap_d  = 1'b1;
      end
    end
  end
  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      pass_q  <= '0;
      lim_q   <= '0;
      step_q  <= WIDTH'(1);
      down_q  <= 1'b0;
      last_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      down_q  <= down_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end
  assign count    = count_q;
  assign pass_idx = pass_q;
  assign busy     = (state_q == RUN);
  assign wrap     = wrap_q;
  assign done     = done_q;
endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: directed and randomized checks of loop_counter against a trace model
module tb_loop_counter;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0, down = 1'b0;
  logic [3:0] limit = '0, step = '0, passes = '0;
  logic [3:0] count, pass_idx;
  logic       busy, wrap, done;
  int         tests = 0, fails = 0;

  loop_counter #(.WIDTH(4), .PASS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause), .down(down),
    .limit(limit), .step(step), .passes(passes),
    .count(count), .pass_idx(pass_idx), .busy(busy), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int p, input int b, input int w, input int d);
    chk({tag, ".count"}, {28'd0, count}, c);
    chk({tag, ".pass_idx"}, {28'd0, pass_idx}, p);
    chk({tag, ".busy"}, {31'd0, busy}, b);
    chk({tag, ".wrap"}, {31'd0, wrap}, w);
    chk({tag, ".done"}, {31'd0, done}, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected count/pass trace from the counting rules, then replays it
  task automatic run(input bit dn, input int lim, input int st, input int ps,
                     input int pa, input int pl, input bit rnd);
    int s = (st == 0) ? 1 : st;
    int p = (ps == 0) ? 1 : ps;
    int term = dn ? 0 : lim;
    int strt = dn ? lim : 0;
    int qc[$], qp[$], qw[$];
    int idx = 0, c = 1;
    bit pz;
    for (int i = 0; i < p; i++) begin
      int v = strt;
      qc.push_back(v); qp.push_back(i); qw.push_back(i > 0 ? 1 : 0);
      while (v != term) begin
        v = dn ? ((v > s) ? v - s : 0) : ((v + s > lim) ? lim : v + s);
        qc.push_back(v); qp.push_back(i); qw.push_back(0);
      end
    end
    down = dn; limit = 4'(lim); step = 4'(st); passes = 4'(ps); start = 1'b1;
    tick();
    chk_all("run.first", qc[0], qp[0], 1, 0, 0);
    while (idx < qc.size() && c < 2000) begin
      pz = ((c >= pa) && (c < pa + pl)) || (rnd && ($urandom_range(0, 3) == 0));
      pause = pz;
      start = 1'($urandom);
      limit = 4'($urandom); step = 4'($urandom); passes = 4'($urandom); down = 1'($urandom);
      tick();
      pause = 1'b0;
      if (!pz) idx++;
      if (idx < qc.size())
        chk_all(pz ? "run.pause" : "run.step", qc[idx], qp[idx], 1, pz ? 0 : qw[idx], 0);
      else
        chk_all("run.done", term, p - 1, 0, 0, 1);
      c++;
    end
    chk("run.bounded", {31'd0, c < 2000}, 1);
    tick();
    start = 1'b0;
    chk_all("run.idle", term, p - 1, 0, 0, 0);
  endtask

  initial begin
    #3;
    chk_all("reset", 0, 0, 0, 0, 0);
    #4 rst_n = 1'b1;
    tick();
    chk_all("idle", 0, 0, 0, 0, 0);
    run(0, 10, 1, 1, 0, 0, 0);
    run(1, 10, 3, 1, 0, 0, 0);
    run(0, 15, 7, 1, 0, 0, 0);
    run(0, 3, 1, 3, 5, 2, 0);
    run(0, 0, 5, 2, 0, 0, 0);
    run(1, 0, 0, 0, 0, 0, 0);
    run(1, 15, 0, 2, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      run(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 4)), 0, 0, 1);
    down = 1'b0; limit = 4'd10; step = 4'd1; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("abort.first", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all("abort.cnt", i, 0, 1, 0, 0);
    end
    start = 1'b1; limit = 4'd2; down = 1'b1;
    tick();
    start = 1'b0;
    chk_all("abort.restart_ignored", 5, 0, 1, 0, 0);
    tick();
    chk_all("abort.cnt6", 6, 0, 1, 0, 0);
    abort = 1'b1; pause = 1'b1; start = 1'b1;
    tick();
    chk_all("abort.hit", 0, 0, 0, 0, 0);
    tick();
    chk_all("abort.start_blocked", 0, 0, 0, 0, 0);
    abort = 1'b0; pause = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("abort.after", 0, 0, 0, 0, 0);
    end
    down = 1'b0; limit = 4'd10; step = 4'd1; passes = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_all("areset.cnt", i, 0, 1, 0, 0);
    end
    #2 rst_n = 1'b0;
    #1 chk_all("areset.async", 0, 0, 0, 0, 0);
    tick();
    chk_all("areset.held", 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all("areset.after", 0, 0, 0, 0, 0);
    end
    run(0, 4, 2, 2, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
